ysyx_22050854_div_ctrl: RTL and testbench

YSYX_22050854_DIV_CTRL -- requirements
Module: ysyx_22050854_div_ctrl

---
 rtl/ysyx_22050854_div_ctrl.sv | 150 +++++++++++++++
 tb/tb_ysyx_22050854_div_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_div_ctrl.sv
// Divide-unit controller: accepts RV64 DIV/REM requests, hands them to an external divider and returns the result.
// Optional macro YSYX_22050854_DIV_FASTPATH_EN resolves divide-by-zero and signed overflow in one cycle.
module ysyx_22050854_div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic        op_word,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [63:0] result,
    output logic        div_valid,
    output logic        divw,
    output logic        div_signed,
    output logic [63:0] dividend,
    output logic [63:0] divisor,
    input  logic        div_ready,
    input  logic        out_valid,
    input  logic [63:0] quotient,
    input  logic [63:0] remainder
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_e;

    state_e      state_q;
    logic [1:0]  op_code_q;
    logic        op_word_q;
    logic [63:0] src1_q;
    logic [63:0] src2_q;
    logic [63:0] result_q;
    logic        divw_q;
    logic        div_signed_q;

    logic        accept;
    logic        fast_hit;
    logic [63:0] fast_res;
    logic [63:0] div_sel;
    logic [63:0] div_res;

    assign op_ready     = (state_q == IDLE) & ~flush;
    assign accept       = op_valid & op_ready;
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign div_valid    = (state_q == ISSUE) & ~flush;
    assign result       = result_q;
    assign divw         = divw_q;
    assign div_signed   = div_signed_q;
    assign dividend     = src1_q;
    assign divisor      = src2_q;

`ifdef YSYX_22050854_DIV_FASTPATH_EN
    logic [63:0] a_eff;
    logic        div_zero;
    logic        sgn_ovf;

    always_comb begin
        a_eff    = op_word ? {{32{src1[31]}}, src1[31:0]} : src1;
        div_zero = op_word ? (src2[31:0] == '0) : (src2 == '0);
        sgn_ovf  = ~op_code[0] & (op_word ?
                   ((src1[31:0] == 32'h8000_0000) & (src2[31:0] == '1)) :
                   ((src1 == 64'h8000_0000_0000_0000) & (src2 == '1)));
        fast_hit = 1'b0;
        fast_res = '0;
        if (div_zero) begin
            fast_hit = 1'b1;
            fast_res = op_code[1] ? a_eff : '1;
        end else if (sgn_ovf) begin
            fast_hit = 1'b1;
            fast_res = op_code[1] ? '0 : a_eff;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // W ops take only the low word from the divider and sign-extend it
    always_comb begin
        div_sel = op_code_q[1] ? remainder : quotient;
        div_res = op_word_q ? {{32{div_sel[31]}}, div_sel[31:0]} : div_sel;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            op_code_q    <= '0;
            op_word_q    <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            result_q     <= '0;
            divw_q       <= 1'b0;
            div_signed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_code_q    <= op_code;
                        op_word_q    <= op_word;
                        src1_q       <= src1;
                        src2_q       <= src2;
                        divw_q       <= op_word;
                        div_signed_q <= ~op_code[0];
                        if (fast_hit) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush)          state_q <= IDLE;
                    else if (div_ready) state_q <= WAIT;
                end
                WAIT: begin
                    // a flush coinciding with the result pulse leaves nothing to drain
                    if (out_valid) begin
                        if (flush) begin
                            state_q <= IDLE;
                        end else begin
                            result_q <= div_res;
                            state_q  <= DONE;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid) state_q <= IDLE;
                end
                DONE: begin
                    if (flush | result_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_div_ctrl.sv
// Scoreboard bench for ysyx_22050854_div_ctrl with a behavioural divider and RV64 reference model.
module tb_ysyx_22050854_div_ctrl;

`ifdef YSYX_22050854_DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [1:0]  op_code;
    logic        op_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;
    logic        div_valid;
    logic        divw;
    logic        div_signed;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    ysyx_22050854_div_ctrl dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_word(op_word), .src1(src1), .src2(src2), .flush(flush),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .div_valid(div_valid), .divw(divw), .div_signed(div_signed),
        .dividend(dividend), .divisor(divisor), .div_ready(div_ready), .out_valid(out_valid),
        .quotient(quotient), .remainder(remainder)
    );

    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          hs_count = 0;
    int          forced_lat = 0;
    bit          kill_pending = 1'b0;
    bit          rr_force_low = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV64M semantics straight from the ISA rules
    function automatic logic [63:0] rv_div(input logic [1:0] op, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [63:0] q, r;
        logic [31:0] q32, r32;
        bit          sgn;
        sgn = !op[0];
        if (w) begin
            if (b[31:0] == 32'd0) begin
                q32 = '1; r32 = a[31:0];
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = a[31:0]; r32 = '0;
            end else if (sgn) begin
                q32 = $signed(a[31:0]) / $signed(b[31:0]);
                r32 = $signed(a[31:0]) % $signed(b[31:0]);
            end else begin
                q32 = a[31:0] / b[31:0];
                r32 = a[31:0] % b[31:0];
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            5: return 64'($urandom_range(1, 50));
            6: return {32'($urandom), 32'd0};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Behavioural divider: random ready, random latency, garbage outside the result pulse
    initial begin : divider_model
        bit          job_active;
        int          lat;
        logic [63:0] job_q, job_r;
        job_active = 1'b0; lat = 0; job_q = '0; job_r = '0;
        div_ready = 1'b0; out_valid = 1'b0; quotient = '0; remainder = '0;
        forever begin
            @(negedge clock);
            out_valid = 1'b0;
            quotient  = {32'($urandom), 32'($urandom)};
            remainder = {32'($urandom), 32'($urandom)};
            if (job_active) begin
                if (lat == 0) begin
                    out_valid  = 1'b1;
                    quotient   = job_q;
                    remainder  = job_r;
                    job_active = 1'b0;
                end else begin
                    lat--;
                end
            end
            div_ready = !job_active && ($urandom_range(0, 2) != 0);
            #4;
            if (reset) begin
                job_active = 1'b0;
            end else if (div_valid && div_ready) begin
                hs_count++;
                job_active = 1'b1;
                lat   = (forced_lat != 0) ? forced_lat : $urandom_range(1, 8);
                job_q = rv_div({1'b0, ~div_signed}, divw, dividend, divisor);
                job_r = rv_div({1'b1, ~div_signed}, divw, dividend, divisor);
                if (divw) begin
                    job_q[63:32] = 32'($urandom);
                    job_r[63:32] = 32'($urandom);
                end
            end
        end
    end

    initial begin : ready_driver
        result_ready = 1'b0;
        forever begin
            @(negedge clock);
            result_ready = !rr_force_low && ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        bit          hold_valid;
        logic [63:0] held;
        bit          prev_ov_live;
        logic [63:0] e;
        hold_valid = 1'b0; held = '0; prev_ov_live = 1'b0;
        forever begin
            @(negedge clock);
            #4;
            if (reset) begin
                hold_valid = 1'b0; prev_ov_live = 1'b0;
                continue;
            end
            if (prev_ov_live) chk("result_valid_after_out_valid", 64'(result_valid), 64'd1);
            if (hold_valid) begin
                chk("done_hold_valid", 64'(result_valid), 64'd1);
                chk("done_hold_result", result, held);
            end
            hold_valid = 1'b0;
            if (result_valid) begin
                if (result_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", result, e);
                    end
                end else begin
                    hold_valid = 1'b1;
                    held = result;
                end
            end
            prev_ov_live = out_valid && !kill_pending;
            if (out_valid) kill_pending = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input bit push,
                         input bit chk_fast);
        int t;
        t = 0;
        @(negedge clock);
        op_valid = 1'b1; op_code = op; op_word = w; src1 = a; src2 = b;
        #4;
        while (!op_ready && t <= 200) begin
            t++;
            @(negedge clock);
            #4;
        end
        if (t > 200) chk("accept_timeout", 64'd0, 64'd1);
        else if (push) exp_q.push_back(exp);
        @(negedge clock);
        op_valid = 1'b0;
        op_code = 2'($urandom); op_word = 1'($urandom);
        src1 = {32'($urandom), 32'($urandom)}; src2 = {32'($urandom), 32'($urandom)};
        if (chk_fast) begin
            #4;
            chk("fast_latency", 64'(result_valid), 64'd1);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clock);
        #4;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            t++;
            @(negedge clock);
            #4;
        end
        if (t >= 2000) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_handshake(input int h);
        int t;
        t = 0;
        while (hs_count == h && t < 200) begin
            t++;
            @(negedge clock);
        end
        if (t >= 200) chk("handshake_timeout", 64'd0, 64'd1);
    endtask

    initial begin : stimulus
        int          h;
        int          t;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        reset = 1'b1; op_valid = 1'b0; flush = 1'b0;
        op_code = '0; op_word = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #4;
        chk("reset_op_ready", 64'(op_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result_valid", 64'(result_valid), 64'd0);
        chk("reset_div_valid", 64'(div_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_operands", dividend | divisor, 64'd0);
        chk("reset_divw_signed", 64'({divw, div_signed}), 64'd0);

        issue(2'b00, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0);
        issue(2'b10, 1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        issue(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b0);
        issue(2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        wait_idle();
        h = hs_count;
        issue(2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, FAST);
        issue(2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1, FAST);
        issue(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b1, FAST);
        issue(2'b00, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1'b1, FAST);
        wait_idle();
        if (FAST) chk("fast_no_div_valid", 64'(hs_count), 64'(h));

        // flush while the divider is working
        forced_lat = 12;
        kill_pending = 1'b1;
        h = hs_count;
        issue(2'b01, 1'b0, 64'd1000, 64'd3, 64'd0, 1'b0, 1'b0);
        wait_handshake(h);
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #4;
        t = 0;
        while (!out_valid && t < 100) begin
            chk("drain_op_ready", 64'(op_ready), 64'd0);
            t++;
            @(negedge clock);
            #4;
        end
        if (t >= 100) chk("drain_timeout", 64'd0, 64'd1);
        chk("drain_pulse_op_ready", 64'(op_ready), 64'd0);
        @(negedge clock);
        #4;
        chk("after_drain_busy", 64'(busy), 64'd0);
        chk("after_drain_op_ready", 64'(op_ready), 64'd1);
        forced_lat = 0;
        issue(2'b00, 1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b0);
        wait_idle();

        // consumer stalls in DONE
        rr_force_low = 1'b1;
        issue(2'b01, 1'b0, 64'd50, 64'd5, 64'd10, 1'b1, 1'b0);
        t = 0;
        #4;
        while (!result_valid && t < 200) begin
            t++;
            @(negedge clock);
            #4;
        end
        if (t >= 200) chk("done_timeout", 64'd0, 64'd1);
        repeat (3) begin
            chk("stall_result_valid", 64'(result_valid), 64'd1);
            chk("stall_result", result, 64'd10);
            @(negedge clock);
            #4;
        end
        rr_force_low = 1'b0;
        wait_idle();
        chk("stall_idle", 64'(busy), 64'd0);

        // reset in the middle of a divide
        forced_lat = 20;
        h = hs_count;
        issue(2'b00, 1'b1, 64'd123, 64'd5, 64'd0, 1'b0, 1'b0);
        wait_handshake(h);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #4;
        chk("midreset_op_ready", 64'(op_ready), 64'd1);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_result_valid", 64'(result_valid), 64'd0);
        chk("midreset_div_valid", 64'(div_valid), 64'd0);
        chk("midreset_result", result, 64'd0);
        chk("midreset_operands", dividend | divisor, 64'd0);
        chk("midreset_divw_signed", 64'({divw, div_signed}), 64'd0);
        forced_lat = 0;
        issue(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = rnd_operand();
            b  = rnd_operand();
            issue(op, w, a, b, rv_div(op, w, a, b), 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        wait_idle();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
